display_arbiter: RTL and testbench

- Shares the 4-digit multiplexed 7-segment display between up to four requesters, e.g. the UART RX byte, the TX byte, the error/status code and a debug word.
- Each requester offers a 16-bit value over a valid/ready handshake. The arbiter grants round-robin, latches the winner's value onto hex3..hex0 and holds it for a minimum dwell time so a human can read it.
- Sits between the UART datapath/status logic and the display controller; hex0..hex3 connect directly to that controller's nibble inputs.

---
 rtl/display_arbiter.sv | 145 ++++++++++++++
 tb/tb_display_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/display_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : display_arbiter
// Brief    : Round-robin sharing of a 4-digit hex display with a minimum dwell
//            per grant. Define DISP_ARB_PREEMPT_EN to let requester 0 preempt.
// Revision : 1.0
// ============================================================================
module display_arbiter #(
    parameter int NUM_REQ      = 3,
    parameter int DWELL_CYCLES = 25_000_000
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [16*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [3:0]              hex0,
    output logic [3:0]              hex1,
    output logic [3:0]              hex2,
    output logic [3:0]              hex3,
    output logic [1:0]              owner,
    output logic                    active
);

    localparam int                 CNT_W        = $clog2(DWELL_CYCLES + 1);
    localparam logic [CNT_W-1:0]   C_CNT_RELOAD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [2:0]         C_NUM_REQ    = 3'(NUM_REQ);
    localparam logic [1:0]         C_LAST       = 2'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_DWELL = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_ptr;
    logic [15:0]        r_value;
    logic [1:0]         r_owner;
    logic               r_active;

    logic [3:0]         w_valid_ext;
    logic [63:0]        w_data_ext;
    logic [2:0]         w_idx;
    logic [1:0]         w_rr_win;
    logic [1:0]         w_win;
    logic [1:0]         w_ptr_nxt;
    logic               w_found;
    logic               w_open;
    logic               w_preempt;
    logic               w_grant;

    // Pad requester buses to the 4-requester maximum so indexing is width-stable.
    assign w_valid_ext = 4'(req_valid);
    assign w_data_ext  = 64'(req_data);

    // Descending scan: the last hit is the closest valid index above the pointer.
    always_comb begin
        w_found  = 1'b0;
        w_rr_win = '0;
        w_idx    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = {1'b0, r_ptr} + 3'(k);
            if (w_idx >= C_NUM_REQ) begin
                w_idx = w_idx - C_NUM_REQ;
            end
            if (w_valid_ext[w_idx[1:0]]) begin
                w_found  = 1'b1;
                w_rr_win = w_idx[1:0];
            end
        end
    end

`ifdef DISP_ARB_PREEMPT_EN
    assign w_preempt = (r_state == S_DWELL) && (r_cnt != '0) &&
                       (r_owner != 2'd0) && req_valid[0];
`else
    assign w_preempt = 1'b0;
`endif

    assign w_open    = (r_state == S_IDLE) || (r_cnt == '0);
    assign w_grant   = rstn && (w_preempt || (w_open && w_found));
    assign w_win     = w_preempt ? 2'd0 : w_rr_win;
    assign w_ptr_nxt = (w_win == C_LAST) ? 2'd0 : (w_win + 2'd1);

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = w_grant && (w_win == 2'(i));
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    w_state_nxt = S_DWELL;
                end
            end
            S_DWELL: begin
                if (!w_grant && (r_cnt == '0)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_value  <= '0;
            r_owner  <= '0;
            r_active <= 1'b0;
            r_ptr    <= '0;
            r_cnt    <= '0;
        end else if (w_grant) begin
            r_value  <= w_data_ext[{w_win, 4'b0000} +: 16];
            r_owner  <= w_win;
            r_active <= 1'b1;
            r_ptr    <= w_ptr_nxt;
            r_cnt    <= C_CNT_RELOAD;
        end else if (r_cnt != '0) begin
            r_cnt    <= r_cnt - CNT_W'(1);
        end
    end

    assign hex0   = r_value[3:0];
    assign hex1   = r_value[7:4];
    assign hex2   = r_value[11:8];
    assign hex3   = r_value[15:12];
    assign owner  = r_owner;
    assign active = r_active;

endmodule
`default_nettype wire

// File: tb/tb_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_arbiter
// Brief    : Scoreboard bench for display_arbiter, NUM_REQ=3, DWELL_CYCLES=4.
// Revision : 1.0
// ============================================================================
module tb_display_arbiter;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic [2:0]     req_valid = '0;
    logic [47:0]    req_data = '0;
    logic [2:0]     req_ready;
    logic [3:0]     hex0, hex1, hex2, hex3;
    logic [1:0]     owner;
    logic           active;

    always #5 clk = ~clk;

    display_arbiter #(
        .NUM_REQ      (3),
        .DWELL_CYCLES (4)
    ) u_dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .hex0      (hex0),
        .hex1      (hex1),
        .hex2      (hex2),
        .hex3      (hex3),
        .owner     (owner),
        .active    (active)
    );

    typedef struct {
        logic [2:0]  rdy;
        logic [1:0]  own;
        logic [15:0] dat;
        int          gap;
    } exp_t;

    exp_t           exp_q[$];
    logic [15:0]    src_q[3][$];
    int             n_checks = 0;
    int             n_pass = 0;
    int             n_grants = 0;
    int             cyc = 0;
    int             last_grant = 0;
    logic [2:0]     seen_ready = '0;
    logic           pend = 1'b0;
    exp_t           pend_e;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
        end
    endtask

    task automatic expect_grant(input logic [2:0] r, input logic [1:0] o,
                                input logic [15:0] d, input int g);
        exp_t e;
        e.rdy = r;
        e.own = o;
        e.dat = d;
        e.gap = g;
        exp_q.push_back(e);
    endtask

    task automatic wait_grants(input int n);
        int t;
        t = 0;
        while (n_grants < n && t < 100) begin
            @(posedge clk);
            t++;
        end
        check_val("grant_count", 32'(n_grants), 32'(n));
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Requester model: hold each queued value until its ready is seen.
    initial forever begin
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (seen_ready[i] && src_q[i].size() > 0) begin
                void'(src_q[i].pop_front());
            end
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            req_valid[i]        = (src_q[i].size() > 0);
            req_data[16*i +: 16] = (src_q[i].size() > 0) ? src_q[i][0] : 16'h0000;
        end
    end

    // Monitor: pop an expectation on every grant, check the display one cycle later.
    initial forever begin
        @(negedge clk);
        seen_ready = req_ready;
        if (pend) begin
            check_val("disp_value",  32'({hex3, hex2, hex1, hex0}), 32'(pend_e.dat));
            check_val("disp_owner",  32'(owner), 32'(pend_e.own));
            check_val("disp_active", 32'(active), 32'h1);
            pend = 1'b0;
        end
        if (req_ready != 3'b000) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_grant", 32'(req_ready), 32'h0);
            end else begin
                pend_e = exp_q.pop_front();
                check_val("grant_ready", 32'(req_ready), 32'(pend_e.rdy));
                if (pend_e.gap != 0) begin
                    check_val("grant_gap", 32'(cyc - last_grant), 32'(pend_e.gap));
                end
                pend = 1'b1;
            end
            last_grant = cyc;
            n_grants++;
        end
    end

    initial begin
        // Reset with every requester asserting valid.
        src_q[0].push_back(16'hAAAA);
        src_q[1].push_back(16'hBBBB);
        src_q[2].push_back(16'hCCCC);
        repeat (3) begin
            @(negedge clk);
            check_val("rst_ready",  32'(req_ready), 32'h0);
            check_val("rst_hex",    32'({hex3, hex2, hex1, hex0}), 32'h0);
            check_val("rst_owner",  32'(owner), 32'h0);
            check_val("rst_active", 32'(active), 32'h0);
        end
        @(posedge clk);
        for (int i = 0; i < 3; i++) src_q[i].delete();
        #2 rstn = 1'b1;

        // Single request from idle, then hold after the dwell expires.
        @(posedge clk);
        src_q[1].push_back(16'hBEEF);
        expect_grant(3'b010, 2'd1, 16'hBEEF, 0);
        wait_grants(1);
        repeat (8) @(posedge clk);
        @(negedge clk);
        check_val("hold_hex",    32'({hex3, hex2, hex1, hex0}), 32'hBEEF);
        check_val("hold_owner",  32'(owner), 32'h1);
        check_val("hold_active", 32'(active), 32'h1);
        check_val("hold_ready",  32'(req_ready), 32'h0);

        // Reset clears the pointer; all three then request continuously.
        @(posedge clk);
        #1 rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_val("rst2_active", 32'(active), 32'h0);
        check_val("rst2_hex",    32'({hex3, hex2, hex1, hex0}), 32'h0);
        @(posedge clk);
        src_q[0].push_back(16'h1111);
        src_q[0].push_back(16'h111A);
        src_q[1].push_back(16'h2222);
        src_q[2].push_back(16'h3333);
`ifdef DISP_ARB_PREEMPT_EN
        expect_grant(3'b001, 2'd0, 16'h1111, 0);
        expect_grant(3'b010, 2'd1, 16'h2222, 4);
        expect_grant(3'b001, 2'd0, 16'h111A, 1);
        expect_grant(3'b100, 2'd2, 16'h3333, 4);
`else
        expect_grant(3'b001, 2'd0, 16'h1111, 0);
        expect_grant(3'b010, 2'd1, 16'h2222, 4);
        expect_grant(3'b100, 2'd2, 16'h3333, 4);
        expect_grant(3'b001, 2'd0, 16'h111A, 4);
`endif
        #2 rstn = 1'b1;
        wait_grants(5);
        repeat (8) @(posedge clk);

        // Owner 2 dwelling; req0 and req1 arrive, pointer wraps to 0.
        src_q[2].push_back(16'h3C3C);
        expect_grant(3'b100, 2'd2, 16'h3C3C, 0);
        wait_grants(6);
        src_q[0].push_back(16'h0A0A);
        src_q[1].push_back(16'h1B1B);
`ifdef DISP_ARB_PREEMPT_EN
        expect_grant(3'b001, 2'd0, 16'h0A0A, 1);
`else
        expect_grant(3'b001, 2'd0, 16'h0A0A, 4);
`endif
        expect_grant(3'b010, 2'd1, 16'h1B1B, 4);
        wait_grants(8);
        repeat (8) @(posedge clk);

        // Reset mid-dwell at cnt==2, then req2 alone wins right after release.
        src_q[1].push_back(16'h5555);
        expect_grant(3'b010, 2'd1, 16'h5555, 0);
        wait_grants(9);
        @(posedge clk);
        src_q[2].push_back(16'h7777);
        #1 rstn = 1'b0;
        @(negedge clk);
        check_val("rst3_ready", 32'(req_ready), 32'h0);
        @(posedge clk);
        @(negedge clk);
        check_val("rst3_hex",    32'({hex3, hex2, hex1, hex0}), 32'h0);
        check_val("rst3_owner",  32'(owner), 32'h0);
        check_val("rst3_active", 32'(active), 32'h0);
        check_val("rst3_ready2", 32'(req_ready), 32'h0);
        expect_grant(3'b100, 2'd2, 16'h7777, 0);
        @(posedge clk);
        #1 rstn = 1'b1;
        wait_grants(10);
        repeat (3) @(posedge clk);

        check_val("exp_q_empty", 32'(exp_q.size()), 32'h0);
        check_val("src_empty",
                  32'(src_q[0].size() + src_q[1].size() + src_q[2].size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
